mc_memory_map: RTL
==================

MC_MEMORY_MAP -- requirements
Module: mc_memory_map

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64: width of each channel rd_addr/wr_addr (max 64).
REQ-002 SHALL have parameter SIZE_WIDTH, default 16: width of each channel size, in cache lines (max 32).
REQ-003 SHALL have parameter NUM_CH, default 4: number of DMA channels (1..8).
REQ-004 SHALL have parameter CH_BASE, default 16'h0050: MMIO address of channel 0 register block.
REQ-005 SHALL have parameter CH_STRIDE, default 16'h0010: address distance between channel blocks.
REQ-006 SHALL have port clk, input, 1: clock.
REQ-007 SHALL have port rst, input, 1: reset (asynchronous, active-high).
REQ-008 SHALL have port mmio, mmio_if.user: MMIO bus (wr_en, wr_addr, wr_data[63:0], rd_en, rd_addr, rd_data[63:0]).
REQ-009 SHALL have port rd_addr, output, NUM_CH x ADDR_WIDTH: per-channel source byte address.
REQ-010 SHALL have port wr_addr, output, NUM_CH x ADDR_WIDTH: per-channel destination byte address.
REQ-011 SHALL have port size, output, NUM_CH x SIZE_WIDTH: per-channel transfer length.
REQ-012 SHALL have port go, output, NUM_CH: per-channel one-cycle start pulse.
REQ-013 SHALL have port done, input, NUM_CH: per-channel completion level from the DMA engine.

Function
REQ-014 SHALL decode channel c offsets at CH_BASE + c*CH_STRIDE: +0 go (W), +2 rd_addr (RW), +4 wr_addr (RW), +6 size (RW), +8 status (R), +A cycle count (R).
REQ-015 SHALL decode global registers: 16'h0040 NUM_CH (R), 16'h0042 reset count (R), 16'h0044 done bitmask, bit c = sticky done of channel c (R).
REQ-016 SHALL capture wr_data[W-1:0] into the addressed rd_addr/wr_addr/size register on the clock edge where wr_en is high.
REQ-017 SHALL, on a go write with wr_data[0]=1 and the channel not busy, drive go[c]=1 for exactly the next cycle, set busy[c], clear sticky done[c], and clear cycle count[c].
REQ-018 SHALL ignore go, rd_addr, wr_addr and size writes to a channel while its busy is set.
REQ-019 SHALL register done into done_r each cycle; a rising edge (done=1, done_r=0) while busy[c] SHALL clear busy[c] and set sticky done[c].
REQ-020 SHALL ignore done edges while not busy.
REQ-021 SHALL increment the 32-bit cycle count[c] every cycle busy[c] is set, saturating at 32'hFFFF_FFFF.
REQ-022 SHALL return status as {62'b0, busy[c], sticky done[c]}.
REQ-023 SHALL register rd_data on the edge where rd_en is high (1-cycle latency), zero-extending narrower fields, and hold rd_data otherwise.
REQ-024 SHALL return 64'h0 for reads of unmapped addresses, write-only go offsets, and channel offsets at c >= NUM_CH; writes there SHALL have no effect.
REQ-025 SHALL, on a read and an update to the same register in one cycle, return the pre-update value.
REQ-026 SHALL, on a done edge and go write to the same busy channel in one cycle, clear busy and drop the go.
REQ-027 SHALL process channels independently; simultaneous activity on different channels SHALL not interact.

Reset
REQ-028 SHALL, while rst is high, force go, rd_addr, wr_addr, size, busy, sticky done, done_r, cycle counts and rd_data to 0.
REQ-029 SHALL abandon an in-flight transfer on rst (busy=0, count=0) with no go pulse after release.
REQ-030 SHALL increment the 64-bit reset count once per rst assertion; the register is not cleared by rst and powers up at 0.

Verification
REQ-031 Write ch1 rd_addr=64'h1000, wr_addr=64'h2000, size=8, go=1 -> go[1] one-cycle pulse, go[0,2,3]=0, status ch1 reads 2'b10.
REQ-032 Start ch1 then raise done[1] 20 cycles after go -> status 2'b01, count=20 (+/-1 per REQ-021), 16'h0044 reads 4'b0010.
REQ-033 Write size=5 to ch2 while busy -> read returns the old size; second go on ch2 produces no pulse.
REQ-034 Read 16'h00D0 (c=8) and 16'h005E -> rd_data=0 one cycle after rd_en.
REQ-035 Go on ch0 and ch3 same cycle, done[3] before done[0] -> each busy clears at its own edge; bitmask 4'b1000 then 4'b1001.
REQ-036 Assert rst mid-transfer on ch0 -> all outputs 0, status 0, reset count increments by 1.

Source files
------------

// File: rtl/mc_memory_map_if.sv
// MMIO bus shared by the DMA memory map and its host.
// Ports: wr_en/wr_addr/wr_data carry single-cycle writes; rd_en/rd_addr request a read,
//        rd_data returns the registered read value one cycle later.
interface mmio_if;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [63:0] wr_data;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [63:0] rd_data;

  // The register block consumes requests and produces read data.
  modport user (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data
  );

  // The bus master issues requests and consumes read data.
  modport host (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data
  );
endinterface

// File: rtl/mc_memory_map.sv
// MMIO register map for a multi-channel DMA engine: per-channel address/size registers,
// start pulses, busy/done tracking, busy cycle counters and global info registers.
// Ports: clk/rst (async active-high), mmio (user side of mmio_if), per-channel rd_addr,
//        wr_addr, size, go outputs and the done input from the DMA engine.
module mc_memory_map #(
  parameter int          ADDR_WIDTH = 64,
  parameter int          SIZE_WIDTH = 16,
  parameter int          NUM_CH     = 4,
  parameter logic [15:0] CH_BASE    = 16'h0050,
  parameter logic [15:0] CH_STRIDE  = 16'h0010
) (
  input  logic                                 clk,
  input  logic                                 rst,
  mmio_if.user                                 mmio,
  output logic [NUM_CH-1:0][ADDR_WIDTH-1:0]    rd_addr,
  output logic [NUM_CH-1:0][ADDR_WIDTH-1:0]    wr_addr,
  output logic [NUM_CH-1:0][SIZE_WIDTH-1:0]    size,
  output logic [NUM_CH-1:0]                    go,
  input  logic [NUM_CH-1:0]                    done
);

  localparam logic [15:0] A_NUM_CH    = 16'h0040;
  localparam logic [15:0] A_RST_CNT   = 16'h0042;
  localparam logic [15:0] A_DONE_MASK = 16'h0044;

  localparam logic [15:0] OFF_GO     = 16'h0;
  localparam logic [15:0] OFF_RD     = 16'h2;
  localparam logic [15:0] OFF_WR     = 16'h4;
  localparam logic [15:0] OFF_SIZE   = 16'h6;
  localparam logic [15:0] OFF_STATUS = 16'h8;
  localparam logic [15:0] OFF_COUNT  = 16'hA;

  function automatic logic [15:0] reg_addr(input int c, input logic [15:0] off);
    return 16'(int'(CH_BASE) + c * int'(CH_STRIDE)) + off;
  endfunction

  logic [NUM_CH-1:0]        busy;
  logic [NUM_CH-1:0]        sticky_done;
  logic [NUM_CH-1:0]        done_r;
  logic [NUM_CH-1:0][31:0]  cycle_cnt;

  // Not cleared by rst; the declaration value gives the power-up zero.
  logic [63:0]              reset_count = 64'd0;

  logic [NUM_CH-1:0] hit_go, hit_rd, hit_wr, hit_size;
  logic [NUM_CH-1:0] start, finish;
  logic [63:0]       rd_val;

  // Write decode and per-channel start/finish qualification.
  always_comb begin
    hit_go   = '0;
    hit_rd   = '0;
    hit_wr   = '0;
    hit_size = '0;
    start    = '0;
    finish   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      hit_go[c]   = mmio.wr_en && (mmio.wr_addr == reg_addr(c, OFF_GO));
      hit_rd[c]   = mmio.wr_en && (mmio.wr_addr == reg_addr(c, OFF_RD));
      hit_wr[c]   = mmio.wr_en && (mmio.wr_addr == reg_addr(c, OFF_WR));
      hit_size[c] = mmio.wr_en && (mmio.wr_addr == reg_addr(c, OFF_SIZE));
      // A done edge only counts while a transfer is in flight.
      finish[c]   = busy[c] && done[c] && !done_r[c];
      // Start requires an idle channel, so a go colliding with a done edge on the
      // same busy channel is dropped.
      start[c]    = hit_go[c] && mmio.wr_data[0] && !busy[c];
    end
  end

  // Per-channel control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr     <= '0;
      wr_addr     <= '0;
      size        <= '0;
      go          <= '0;
      busy        <= '0;
      sticky_done <= '0;
      done_r      <= '0;
      cycle_cnt   <= '0;
    end else begin
      done_r <= done;
      for (int c = 0; c < NUM_CH; c++) begin
        go[c] <= start[c];

        if (finish[c]) begin
          busy[c]        <= 1'b0;
          sticky_done[c] <= 1'b1;
        end else if (start[c]) begin
          busy[c]        <= 1'b1;
          sticky_done[c] <= 1'b0;
        end

        if (start[c]) begin
          cycle_cnt[c] <= '0;
        end else if (busy[c] && (cycle_cnt[c] != 32'hFFFF_FFFF)) begin
          cycle_cnt[c] <= cycle_cnt[c] + 32'd1;
        end

        // Transfer parameters are frozen while the engine is using them.
        if (!busy[c]) begin
          if (hit_rd[c])   rd_addr[c] <= mmio.wr_data[ADDR_WIDTH-1:0];
          if (hit_wr[c])   wr_addr[c] <= mmio.wr_data[ADDR_WIDTH-1:0];
          if (hit_size[c]) size[c]    <= mmio.wr_data[SIZE_WIDTH-1:0];
        end
      end
    end
  end

  // Clocked by the reset net itself so every assertion is counted exactly once,
  // even one that spans no clock edge.
  always_ff @(posedge rst) begin
    reset_count <= reset_count + 64'd1;
  end

  // Read mux works on current (pre-update) register values.
  always_comb begin
    rd_val = '0;
    case (mmio.rd_addr)
      A_NUM_CH:    rd_val = 64'(NUM_CH);
      A_RST_CNT:   rd_val = reset_count;
      A_DONE_MASK: rd_val = 64'(sticky_done);
      default:     rd_val = '0;
    endcase
    for (int c = 0; c < NUM_CH; c++) begin
      if (mmio.rd_addr == reg_addr(c, OFF_RD))     rd_val = 64'(rd_addr[c]);
      if (mmio.rd_addr == reg_addr(c, OFF_WR))     rd_val = 64'(wr_addr[c]);
      if (mmio.rd_addr == reg_addr(c, OFF_SIZE))   rd_val = 64'(size[c]);
      if (mmio.rd_addr == reg_addr(c, OFF_STATUS)) rd_val = {62'b0, busy[c], sticky_done[c]};
      if (mmio.rd_addr == reg_addr(c, OFF_COUNT))  rd_val = 64'(cycle_cnt[c]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mmio.rd_data <= '0;
    end else if (mmio.rd_en) begin
      mmio.rd_data <= rd_val;
    end
  end

endmodule
